// File: rtl/riscv_pkg.sv
// Shared RV32 EX-stage definitions: divide op codes, forwarding selects, divider state encoding.
package riscv_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef logic [1:0] div_state_t;
  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t CALC = 2'd1;
  localparam div_state_t DONE = 2'd2;

endpackage

// File: rtl/fwd_operand_mux.sv
// 3:1 operand select driven by a forwarding-unit code; unused code 11 falls back to the regfile.
module fwd_operand_mux
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] ex_mem_data,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic [XLEN-1:0] operand_c
);

  always_comb begin
    operand_c = rf_data;
    case (sel)
      FWD_EX_MEM: operand_c = ex_mem_data;
      FWD_MEM_WB: operand_c = mem_wb_data;
      default:    operand_c = rf_data;
    endcase
  end

endmodule

// File: rtl/ex_div_unit.sv
// RV32M multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU) for the EX stage.
// Optional DIV_EARLY_OUT_EN: trivial operand pairs complete one cycle after start.
module ex_div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      div_op,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] ex_mem_data,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            ex_stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  div_state_t       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [XLEN-1:0]  quo_q, quo_n;
  logic [XLEN-1:0]  rem_q, rem_n;
  logic [XLEN-1:0]  divisor_q, divisor_n;
  logic             neg_quo_q, neg_quo_n;
  logic             neg_rem_q, neg_rem_n;
  logic             is_rem_q, is_rem_n;
  logic [XLEN-1:0]  result_q, result_n;
  logic             done_q, done_n;

  logic [XLEN-1:0]  op_a_c, op_b_c;

  fwd_operand_mux #(.XLEN(XLEN)) u_fwd_a (
    .sel         (forwardA),
    .rf_data     (rs1_data),
    .ex_mem_data (ex_mem_data),
    .mem_wb_data (mem_wb_data),
    .operand_c   (op_a_c)
  );

  fwd_operand_mux #(.XLEN(XLEN)) u_fwd_b (
    .sel         (forwardB),
    .rf_data     (rs2_data),
    .ex_mem_data (ex_mem_data),
    .mem_wb_data (mem_wb_data),
    .operand_c   (op_b_c)
  );

  // Operand magnitudes and sign handling, only meaningful in the start cycle
  logic            is_signed_c, sign_a_c, sign_b_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c;

  assign is_signed_c = ~div_op[0];
  assign sign_a_c    = is_signed_c & op_a_c[XLEN-1];
  assign sign_b_c    = is_signed_c & op_b_c[XLEN-1];
  assign abs_a_c     = sign_a_c ? -op_a_c : op_a_c;
  assign abs_b_c     = sign_b_c ? -op_b_c : op_b_c;

  // One restoring step: shift next dividend bit in, subtract if it fits
  logic [XLEN:0]   rem_sh_c, diff_c;
  logic            q_bit_c;
  logic [XLEN-1:0] rem_step_c, quo_step_c, quo_fix_c, rem_fix_c, result_fin_c;

  assign rem_sh_c     = {rem_q, quo_q[XLEN-1]};
  assign diff_c       = rem_sh_c - {1'b0, divisor_q};
  assign q_bit_c      = ~diff_c[XLEN];
  assign rem_step_c   = q_bit_c ? diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];
  assign quo_step_c   = {quo_q[XLEN-2:0], q_bit_c};
  assign quo_fix_c    = neg_quo_q ? -quo_step_c : quo_step_c;
  assign rem_fix_c    = neg_rem_q ? -rem_step_c : rem_step_c;
  assign result_fin_c = is_rem_q ? rem_fix_c : quo_fix_c;

`ifdef DIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            b_zero_c, ovf_c, early_c;
  logic [XLEN-1:0] early_quo_c, early_rem_c, early_result_c;

  assign b_zero_c       = (op_b_c == '0);
  assign ovf_c          = is_signed_c & (op_a_c == INT_MIN) & (op_b_c == '1);
  assign early_c        = b_zero_c | ovf_c | (abs_a_c < abs_b_c);
  assign early_quo_c    = b_zero_c ? '1 : (ovf_c ? INT_MIN : '0);
  assign early_rem_c    = ovf_c ? '0 : op_a_c;
  assign early_result_c = div_op[1] ? early_rem_c : early_quo_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      quo_q     <= quo_n;
      rem_q     <= rem_n;
      divisor_q <= divisor_n;
      neg_quo_q <= neg_quo_n;
      neg_rem_q <= neg_rem_n;
      is_rem_q  <= is_rem_n;
      result_q  <= result_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    quo_n     = quo_q;
    rem_n     = rem_q;
    divisor_n = divisor_q;
    neg_quo_n = neg_quo_q;
    neg_rem_n = neg_rem_q;
    is_rem_n  = is_rem_q;
    result_n  = result_q;
    done_n    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          quo_n     = abs_a_c;
          rem_n     = '0;
          divisor_n = abs_b_c;
          // Divide by zero keeps the all-ones quotient unnegated
          neg_quo_n = (sign_a_c ^ sign_b_c) & (|op_b_c);
          neg_rem_n = sign_a_c;
          is_rem_n  = div_op[1];
          cnt_n     = CNT_W'(XLEN - 1);
          state_n   = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (early_c) begin
            state_n  = DONE;
            done_n   = 1'b1;
            result_n = early_result_c;
          end
`endif
        end
      end
      CALC: begin
        quo_n = quo_step_c;
        rem_n = rem_step_c;
        if (cnt_q == '0) begin
          state_n  = DONE;
          done_n   = 1'b1;
          result_n = result_fin_c;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (flush) begin
      state_n  = IDLE;
      done_n   = 1'b0;
      result_n = result_q;
    end
  end

  assign ex_stall = ((state_q == IDLE) & start & ~flush) | (state_q == CALC);
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed vector table plus flush/reset sequences.
module tb_ex_div_unit;

  localparam int unsigned XLEN = 32;
  localparam int          LAT  = 33;

  logic            clk;
  logic            rst;
  logic            start;
  logic            flush;
  logic [1:0]      div_op;
  logic [1:0]      forwardA;
  logic [1:0]      forwardB;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] ex_mem_data;
  logic [XLEN-1:0] mem_wb_data;
  logic            ex_stall;
  logic            done;
  logic [XLEN-1:0] result;

  ex_div_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .div_op      (div_op),
    .forwardA    (forwardA),
    .forwardB    (forwardB),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .ex_mem_data (ex_mem_data),
    .mem_wb_data (mem_wb_data),
    .ex_stall    (ex_stall),
    .done        (done),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exm;
    logic [31:0] mwb;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [31:0] GX = 32'hDEAD_0001;
  localparam logic [31:0] GY = 32'hBEEF_0002;
  localparam int NV = 23;

  vec_t        vecs [NV];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_result = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input bit early);
`ifdef DIV_EARLY_OUT_EN
    return early ? 1 : LAT;
`else
    return (early && 1'b0) ? 1 : LAT;
`endif
  endfunction

  // Caller is positioned at a negedge; this cycle is the start cycle T
  task automatic run_vec(input vec_t v);
    int lat;
    bit stall_ok;
    div_op = v.op; forwardA = v.fa; forwardB = v.fb;
    rs1_data = v.rs1; rs2_data = v.rs2; ex_mem_data = v.exm; mem_wb_data = v.mwb;
    start = 1'b1; flush = 1'b0;
    #1;
    chk({v.name, ".stall_T"}, 32'(ex_stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    forwardA = 2'($urandom); forwardB = 2'($urandom);
    rs1_data = $urandom; rs2_data = $urandom; ex_mem_data = $urandom; mem_wb_data = $urandom;
    div_op = 2'($urandom);
    lat = 0;
    stall_ok = 1'b1;
    for (int k = 1; k <= LAT + 8; k++) begin
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!ex_stall) stall_ok = 1'b0;
      @(negedge clk);
    end
    chk({v.name, ".latency"}, 32'(lat), 32'(exp_latency(v.early)));
    chk({v.name, ".result"}, result, v.exp);
    chk({v.name, ".stall_busy"}, 32'(stall_ok), 32'd1);
    chk({v.name, ".stall_done"}, 32'(ex_stall), 32'd0);
    @(negedge clk);
    #1;
    chk({v.name, ".done_pulse"}, 32'(done), 32'd0);
    chk({v.name, ".result_hold"}, result, v.exp);
    last_result = v.exp;
  endtask

  task automatic count_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      #1;
      if (done || ex_stall) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0]  = '{"divu_100_7",  OP_DIVU, 2'b00, 2'b00, 32'd100,      32'd7,        GX, GY, 32'd14,       1'b0};
    vecs[1]  = '{"remu_100_7",  OP_REMU, 2'b00, 2'b00, 32'd100,      32'd7,        GX, GY, 32'd2,        1'b0};
    vecs[2]  = '{"div_m7_2",    OP_DIV,  2'b00, 2'b00, 32'hFFFFFFF9, 32'd2,        GX, GY, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{"rem_m7_2",    OP_REM,  2'b00, 2'b00, 32'hFFFFFFF9, 32'd2,        GX, GY, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{"rem_7_m2",    OP_REM,  2'b00, 2'b00, 32'd7,        32'hFFFFFFFE, GX, GY, 32'd1,        1'b0};
    vecs[5]  = '{"div_7_m2",    OP_DIV,  2'b00, 2'b00, 32'd7,        32'hFFFFFFFE, GX, GY, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{"divu_5_0",    OP_DIVU, 2'b00, 2'b00, 32'd5,        32'd0,        GX, GY, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{"remu_5_0",    OP_REMU, 2'b00, 2'b00, 32'd5,        32'd0,        GX, GY, 32'd5,        1'b1};
    vecs[8]  = '{"div_ovf",     OP_DIV,  2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, GX, GY, 32'h80000000, 1'b1};
    vecs[9]  = '{"rem_ovf",     OP_REM,  2'b00, 2'b00, 32'h80000000, 32'hFFFFFFFF, GX, GY, 32'd0,        1'b1};
    vecs[10] = '{"fwd_10_01",   OP_DIVU, 2'b10, 2'b01, 32'd0,        32'd0,        32'd40, 32'd8,  32'd5, 1'b0};
    vecs[11] = '{"fwd_01_10",   OP_DIVU, 2'b01, 2'b10, 32'd0,        32'd0,        32'd6,  32'd48, 32'd8, 1'b0};
    vecs[12] = '{"fwd_11",      OP_DIVU, 2'b11, 2'b00, 32'd50,       32'd5,        32'd40, 32'd8,  32'd10, 1'b0};
    vecs[13] = '{"divu_3_9",    OP_DIVU, 2'b00, 2'b00, 32'd3,        32'd9,        GX, GY, 32'd0,        1'b1};
    vecs[14] = '{"divu_9_0",    OP_DIVU, 2'b00, 2'b00, 32'd9,        32'd0,        GX, GY, 32'hFFFFFFFF, 1'b1};
    vecs[15] = '{"div_m100_0",  OP_DIV,  2'b00, 2'b00, 32'hFFFFFF9C, 32'd0,        GX, GY, 32'hFFFFFFFF, 1'b1};
    vecs[16] = '{"rem_m100_0",  OP_REM,  2'b00, 2'b00, 32'hFFFFFF9C, 32'd0,        GX, GY, 32'hFFFFFF9C, 1'b1};
    vecs[17] = '{"div_m100_7",  OP_DIV,  2'b00, 2'b00, 32'hFFFFFF9C, 32'd7,        GX, GY, 32'hFFFFFFF2, 1'b0};
    vecs[18] = '{"rem_m3_9",    OP_REM,  2'b00, 2'b00, 32'hFFFFFFFD, 32'd9,        GX, GY, 32'hFFFFFFFD, 1'b1};
    vecs[19] = '{"divu_max_1",  OP_DIVU, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        GX, GY, 32'hFFFFFFFF, 1'b0};
    vecs[20] = '{"divu_eq",     OP_DIVU, 2'b00, 2'b00, 32'd9,        32'd9,        GX, GY, 32'd1,        1'b0};
    vecs[21] = '{"divu_max_16", OP_DIVU, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd16,       GX, GY, 32'h0FFFFFFF, 1'b0};
    vecs[22] = '{"div_min_2",   OP_DIV,  2'b00, 2'b00, 32'h80000000, 32'd2,        GX, GY, 32'hC0000000, 1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; div_op = 2'b00;
    forwardA = 2'b00; forwardB = 2'b00;
    rs1_data = '0; rs2_data = '0; ex_mem_data = '0; mem_wb_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.ex_stall", 32'(ex_stall), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.result", result, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      run_vec(vecs[i]);
    end

    // Flush in CALC at T+10, then restart at T+11
    @(negedge clk);
    div_op = OP_DIVU; forwardA = 2'b00; forwardB = 2'b00;
    rs1_data = 32'd100; rs2_data = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush.stall_T10", 32'(ex_stall), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush.stall_T11", 32'(ex_stall), 32'd0);
    chk("flush.done_T11", 32'(done), 32'd0);
    chk("flush.result_kept", result, last_result);
    v = '{"restart_81_9", OP_DIVU, 2'b00, 2'b00, 32'd81, 32'd9, GX, GY, 32'd9, 1'b0};
    run_vec(v);

    // Start and flush in the same cycle: nothing happens
    @(negedge clk);
    div_op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
    forwardA = 2'b00; forwardB = 2'b00;
    start = 1'b1; flush = 1'b1;
    #1;
    chk("start_flush.stall", 32'(ex_stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    count_quiet("start_flush.quiet", LAT + 5);
    chk("start_flush.result_kept", result, last_result);

    // Reset in the middle of a calculation
    @(negedge clk);
    div_op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset.result", result, 32'd0);
    chk("midreset.done", 32'(done), 32'd0);
    chk("midreset.ex_stall", 32'(ex_stall), 32'd0);
    rst = 1'b0;
    count_quiet("midreset.quiet", LAT + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
